// File: rtl/xc_pkg.sv
// Shared types and helpers for the XOR-complement datapath arbiter.
package xc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } xc_state_t;

  localparam int XC_WIDTH = 20;

  // Constant-only helper used to size the pointer and wait-counter registers.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/xc_arbiter_rr_pick.sv
// Combinational circular priority search: the first set request at or after ptr wins.
module xc_rr_pick
  import xc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] pos;

  // Wrap is done by subtraction so non-power-of-2 requester counts stay in range.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      pos = sum[PTR_W-1:0];
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/xc_arbiter.sv
// Round-robin scheduler sharing one XOR-complement datapath among N_REQ requesters,
// with grant locking for chained bursts and a bounded wait that forces an error response.
module xc_arbiter
  import xc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = XC_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_v,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0]       req_lock,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   dp_v_a,
  output logic [WIDTH-1:0]       dp_a,
  input  logic                   dp_v_q,
  input  logic [WIDTH-1:0]       dp_q,
  output logic [N_REQ-1:0]       rsp_v,
  output logic [WIDTH-1:0]       rsp_q,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT);

  xc_state_t        state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;
  logic             timed_out;

  xc_rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .req  (req_v),
    .ptr  (ptr),
    .grant(grant),
    .index(win_idx),
    .any  (win_any)
  );

  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    dp_v_a    = 1'b0;
    rsp_v     = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (!rst) req_ready = grant;
        if (win_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        dp_v_a    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (dp_v_q || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_v[owner] = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A result arriving on the last wait cycle takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      dp_a    <= '0;
      rsp_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            dp_a  <= req_a[int'(win_idx)*WIDTH +: WIDTH];
            owner <= win_idx;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (dp_v_q) begin
            rsp_q   <= dp_q;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_q   <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: begin
          if (req_lock[owner])                   ptr <= owner;
          else if (owner == PTR_W'(N_REQ - 1))   ptr <= '0;
          else                                   ptr <= owner + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_arbiter.sv
// Scoreboard bench for xc_arbiter: a behavioural datapath model answers operands,
// expected responses are queued when requests are driven and checked as they appear.
module tb_xc_arbiter;

  localparam int N  = 4;
  localparam int W  = 20;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_v;
  logic [N*W-1:0] req_a;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   req_ready;
  logic           dp_v_a;
  logic [W-1:0]   dp_a;
  logic           dp_v_q;
  logic [W-1:0]   dp_q;
  logic [N-1:0]   rsp_v;
  logic [W-1:0]   rsp_q;
  logic           rsp_err;
  logic           busy;

  xc_arbiter #(
    .N_REQ(N),
    .WIDTH(W),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_v    (req_v),
    .req_a    (req_a),
    .req_lock (req_lock),
    .req_ready(req_ready),
    .dp_v_a   (dp_v_a),
    .dp_a     (dp_a),
    .dp_v_q   (dp_v_q),
    .dp_q     (dp_q),
    .rsp_v    (rsp_v),
    .rsp_q    (rsp_q),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] v;
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         rsp_count = 0;
  logic [W-1:0] opnd [N];
  logic [W-1:0] exp_prev = '0;
  logic [W-1:0] dp_prev = '0;
  int         dp_mode = 0;
  int         dp_lat = 7;
  int         stray_cnt = 0;

  // Reference for the external datapath: XOR with the previous result, then negate.
  function automatic logic [W-1:0] xc_fn(input logic [W-1:0] a, input logic [W-1:0] prev);
    return (~(a ^ prev)) + W'(1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pushExpect(input int owner, input bit timeout);
    exp_t e;
    e.v = N'(1) << owner;
    if (timeout) begin
      e.q   = '0;
      e.err = 1'b1;
    end else begin
      e.q      = xc_fn(opnd[owner], exp_prev);
      exp_prev = e.q;
      e.err    = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] lock);
    @(negedge clk);
    req_v    = v;
    req_lock = lock;
  endtask

  // Follows one operation from its accept cycle (0) and notes when things happen.
  task automatic trackOp(input int ncyc, output int dp_cyc, output int rsp_cyc, output logic busy_after);
    dp_cyc     = -1;
    rsp_cyc    = -1;
    busy_after = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) req_v = '0;
      if (dp_v_a && dp_cyc < 0) dp_cyc = c;
      if (rsp_cyc >= 0 && c == rsp_cyc + 1) busy_after = busy;
      if (rsp_v != '0 && rsp_cyc < 0) rsp_cyc = c;
    end
  endtask

  task automatic waitResponses(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (rsp_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, rsp_count, target);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Response monitor: pops the scoreboard for every response the DUT presents.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && rsp_v != '0) begin
        rsp_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_v), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_v", 32'(rsp_v), 32'(e.v));
          checkOutput("rsp_q", 32'(rsp_q), 32'(e.q));
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  // Datapath model: answers dp_v_a after dp_lat cycles unless disabled or reset intervenes.
  initial begin
    int   stray_done;
    bit   aborted;
    logic [W-1:0] res;
    stray_done = 0;
    dp_v_q = 1'b0;
    dp_q   = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        dp_v_q = 1'b1;
        dp_q   = 20'h12345;
        @(negedge clk);
        dp_v_q = 1'b0;
      end else if (!rst && dp_v_a && dp_mode == 0) begin
        res     = xc_fn(dp_a, dp_prev);
        aborted = 1'b0;
        for (int i = 0; i < dp_lat; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          dp_v_q  = 1'b1;
          dp_q    = res;
          dp_prev = res;
          @(negedge clk);
          dp_v_q  = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   dc, rc, base;
    logic ba;

    opnd[0] = 20'h00005;
    opnd[1] = 20'hA5A5A;
    opnd[2] = 20'h0F0F0;
    opnd[3] = 20'h12345;
    for (int i = 0; i < N; i++) req_a[i*W +: W] = opnd[i];
    rst      = 1'b1;
    req_v    = 4'hF;
    req_lock = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dp_v_a", 32'(dp_v_a), 32'd0);
    checkOutput("rst_dp_a", 32'(dp_a), 32'd0);
    checkOutput("rst_rsp_v", 32'(rsp_v), 32'd0);
    checkOutput("rst_rsp_q", 32'(rsp_q), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst   = 1'b0;
    req_v = '0;
    repeat (2) @(negedge clk);

    // Single request, result 0xFFFFB one cycle before the response.
    $display("[TB] single request");
    dp_mode = 0;
    dp_lat  = 7;
    pushExpect(0, 1'b0);
    applyStimulus(4'b0001, 4'b0000);
    #1;
    checkOutput("single_ready", 32'(req_ready), 32'b0001);
    trackOp(14, dc, rc, ba);
    checkOutput("single_dp_cycle", 32'(dc), 32'd1);
    checkOutput("single_rsp_cycle", 32'(rc), 32'd9);
    checkOutput("single_busy_after", 32'(ba), 32'd0);

    // Fairness from ptr=0 with every requester asking.
    $display("[TB] fairness");
    doReset();
    dp_lat = 2;
    pushExpect(0, 1'b0);
    pushExpect(1, 1'b0);
    pushExpect(2, 1'b0);
    pushExpect(3, 1'b0);
    pushExpect(0, 1'b0);
    base = rsp_count;
    applyStimulus(4'hF, 4'h0);
    waitResponses("fair_count", base + 5, 200);
    req_v = '0;

    // Move ptr to 2, then a locked burst from requester 2.
    $display("[TB] lock burst");
    pushExpect(1, 1'b0);
    base = rsp_count;
    applyStimulus(4'b0010, 4'h0);
    waitResponses("lock_pre_count", base + 1, 100);
    req_v = '0;
    pushExpect(2, 1'b0);
    pushExpect(2, 1'b0);
    pushExpect(2, 1'b0);
    pushExpect(3, 1'b0);
    base = rsp_count;
    applyStimulus(4'hF, 4'b0100);
    waitResponses("lock_first_two", base + 2, 100);
    @(negedge clk);
    req_lock = '0;
    waitResponses("lock_count", base + 4, 100);
    req_v = '0;

    // Datapath silent: error response at TIMEOUT+2, then a normal one.
    $display("[TB] timeout");
    dp_mode = 1;
    pushExpect(2, 1'b1);
    applyStimulus(4'b0100, 4'h0);
    #1;
    checkOutput("to_ready", 32'(req_ready), 32'b0100);
    trackOp(24, dc, rc, ba);
    checkOutput("to_rsp_cycle", 32'(rc), 32'(TO + 2));
    dp_mode = 0;
    dp_lat  = 3;
    pushExpect(2, 1'b0);
    applyStimulus(4'b0100, 4'h0);
    trackOp(10, dc, rc, ba);
    checkOutput("after_to_rsp_cycle", 32'(rc), 32'd5);

    // Result arrives on the final wait cycle.
    $display("[TB] result on timeout cycle");
    dp_lat = TO;
    pushExpect(1, 1'b0);
    applyStimulus(4'b0010, 4'h0);
    trackOp(24, dc, rc, ba);
    checkOutput("edge_rsp_cycle", 32'(rc), 32'(TO + 2));

    // Stray result while idle.
    $display("[TB] stray dp_v_q");
    @(negedge clk);
    stray_cnt++;
    repeat (3) @(negedge clk);
    checkOutput("stray_busy", 32'(busy), 32'd0);
    dp_lat = 2;
    pushExpect(0, 1'b0);
    applyStimulus(4'b0001, 4'h0);
    trackOp(8, dc, rc, ba);
    checkOutput("stray_next_rsp_cycle", 32'(rc), 32'd4);

    // Reset while waiting aborts the operation.
    $display("[TB] reset in WAIT");
    dp_lat = 10;
    applyStimulus(4'b0001, 4'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_v = '0;
    end
    checkOutput("rstw_busy_before", 32'(busy), 32'd1);
    rst   = 1'b1;
    req_v = 4'hF;
    @(negedge clk);
    #1;
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    checkOutput("rstw_dp_v_a", 32'(dp_v_a), 32'd0);
    checkOutput("rstw_dp_a", 32'(dp_a), 32'd0);
    checkOutput("rstw_rsp_v", 32'(rsp_v), 32'd0);
    checkOutput("rstw_rsp_q", 32'(rsp_q), 32'd0);
    checkOutput("rstw_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rstw_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    req_v = '0;
    repeat (15) @(negedge clk);
    dp_lat = 4;
    pushExpect(2, 1'b0);
    applyStimulus(4'b0100, 4'h0);
    trackOp(10, dc, rc, ba);
    checkOutput("post_rst_rsp_cycle", 32'(rc), 32'd6);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
